uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequences and configures the uart rx receiver and buffers its output for the host.
//  Applies host line settings (parity, baud mode, data length) only while the line is quiet,
//  and pulses rx_reset to load them. Watchdogs stuck frames.
//  Pushes received bytes plus error flags into a FIFO that the host drains with valid/ready.
// PARAMETERS
//  DEPTH          8      FIFO entries, power of 2, >=2
//  IDLE_CLKS      840    consecutive high-line clocks required before a config apply
//  FRAME_TIMEOUT  65535  clocks in ST_FRAME without rx_data_ready before a resync
//  DROP_ERR       0      1: discard bytes with parity/frame error (still counted)
// PORTS
//  clock          in   1  system clock
//  reset          in   1  synchronous, active-high
//  serial_in      in   1  raw RX line, same net that drives the receiver
//  cfg_parity_en  in   1  requested parity enable
//  cfg_baud_mode  in   1  requested baud mode (0 = 9600, 1 = fast)
//  cfg_datalen    in   1  requested data length (0 = 7 bit, 1 = 8 bit)
//  cfg_update     in   1  1-clk strobe: capture cfg_* into shadow, set pending
//  cfg_pending    out  1  shadow config not yet applied
//  rx_parity_en   out  1  active config to receiver
//  rx_baud_mode   out  1  active config to receiver
//  rx_datalen     out  1  active config to receiver
//  rx_reset       out  1  1-clk reset pulse to receiver
//  rx_data_ready  in   1  receiver byte strobe
//  rx_data        in   8  receiver byte
//  rx_parity_err  in   1  receiver parity error, valid with rx_data_ready
//  rx_frame_err   in   1  receiver frame error, valid with rx_data_ready
//  m_valid        out  1  FIFO not empty
//  m_data         out  10 {frame_err, parity_err, byte} at FIFO head
//  m_ready        in   1  host pop; pop occurs when m_valid & m_ready
//  overrun        out  1  sticky: a byte was dropped because the FIFO was full
//  timeout        out  1  sticky: watchdog fired
//  err_count      out  8  saturating count of bytes with parity or frame error
//  status_clear   in   1  clears overrun, timeout and err_count (a same-cycle increment is lost)
// BEHAVIOUR
//  Reset: all outputs 0, except rx_reset = 1 for the cycle after reset deasserts.
//   FIFO is empty. Active and shadow config are 0. State is ST_IDLE.
//  serial_in passes through a 2-flop synchroniser (2 clk latency) -> ser_s.
//  Idle counter: counts clocks with ser_s == 1, saturating at IDLE_CLKS; cleared by ser_s == 0.
//  cfg_update in any state: shadow <= cfg_*, cfg_pending <= 1.
//   A later update before apply overwrites the shadow.
//  FSM:
//   ST_IDLE : if cfg_pending && idle counter == IDLE_CLKS -> ST_APPLY.
//             else if ser_s == 0 -> ST_FRAME, watchdog <= 0.
//   ST_FRAME: watchdog increments each clock.
//             rx_data_ready -> push decision, ST_IDLE.
//             watchdog == FRAME_TIMEOUT-1 -> timeout <= 1, rx_reset pulse, ST_IDLE.
//   ST_APPLY: active <= shadow, cfg_pending <= 0, rx_reset = 1 for exactly this cycle -> ST_IDLE.
//  Priority: apply beats frame start only when the idle counter is saturated.
//   A line falling in the same cycle loses; the frame restarts after the apply.
//  rx_data_ready in ST_IDLE or ST_APPLY (glitch) is ignored and not counted.
//  Push decision, made on the rx_data_ready cycle:
//   err = rx_parity_err | rx_frame_err; err_count += err, saturating at 255.
//   DROP_ERR && err: no push. FIFO full and no pop: no push, overrun <= 1.
//   FIFO full with a pop in the same cycle: push accepted.
//  FIFO: DEPTH entries, log2(DEPTH)+1-bit pointers; full when the MSBs differ and the rest are equal.
//   m_data is the registered head, valid the cycle m_valid rises.
//   Pop on an empty FIFO is ignored.
//   Simultaneous push and pop on an empty FIFO: the byte appears next cycle and the pop is a no-op.
//  Outputs rx_parity_en, rx_baud_mode and rx_datalen change only in ST_APPLY.
//   They never change mid-frame.
//  Reset mid-frame: FIFO flushed, pending config lost, receiver re-reset via rx_reset.
// STRUCTURE
//  uart_pkg: state encodings ST_IDLE/ST_FRAME/ST_APPLY (2 bits), CFG_W = 3,
//   FIFO entry width 10, error-bit positions within the entry.
//  Sub-module uart_sync_fifo (DEPTH, WIDTH=10): push/pop/full/empty/head.
//  The FSM, synchroniser, idle counter, watchdog and status registers stay in uart_rx_ctrl.
// TESTING
//  Params: DEPTH=4, IDLE_CLKS=8, FRAME_TIMEOUT=64. Receiver is a behavioural stub.
//  1. Line high; cfg_update {1,1,1} -> cfg_pending=1.
//     9 clks after the synchroniser -> rx_reset pulses 1 clk, rx_* = 1/1/1, cfg_pending = 0.
//  2. cfg_update, then line low at idle count 5 -> ST_FRAME and no apply.
//     Stub returns 0xA5 -> m_data = 0x0A5. Apply follows 8 high clks later.
//  3. Five error-free bytes with m_ready = 0 -> 4 entries held, overrun = 1.
//     Pops return the first 4 bytes in order.
//  4. Byte 0x3C with rx_frame_err=1: DROP_ERR=0 -> m_data = 0x23C, err_count = 1.
//     DROP_ERR=1 -> FIFO empty, err_count = 1.
//  5. Line low, no rx_data_ready -> timeout = 1 and rx_reset pulse at clk 64 of ST_FRAME.
//     status_clear -> 0.
//  6. Full FIFO with push and pop in the same cycle -> count stays 4, no overrun.
//     300 error bytes -> err_count = 255.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller and its output FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam int unsigned CFG_W       = 3;
  localparam int unsigned ENTRY_W     = 10;
  localparam int unsigned ERR_PAR_BIT = 8;
  localparam int unsigned ERR_FRM_BIT = 9;

  typedef struct packed {
    logic parity_en;
    logic baud_mode;
    logic datalen;
  } cfg_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read straight from the register array.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART receiver: applies line config while idle, watchdogs frames,
// and buffers received bytes with error flags for the host.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned IDLE_CLKS     = 840,
  parameter int unsigned FRAME_TIMEOUT = 65535,
  parameter int unsigned DROP_ERR      = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         cfg_parity_en,
  input  logic         cfg_baud_mode,
  input  logic         cfg_datalen,
  input  logic         cfg_update,
  output logic         cfg_pending,
  output logic         rx_parity_en,
  output logic         rx_baud_mode,
  output logic         rx_datalen,
  output logic         rx_reset,
  input  logic         rx_data_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_parity_err,
  input  logic         rx_frame_err,
  output logic         m_valid,
  output logic [9:0]   m_data,
  input  logic         m_ready,
  output logic         overrun,
  output logic         timeout,
  output logic [7:0]   err_count,
  input  logic         status_clear
);

  localparam int unsigned IW = $clog2(IDLE_CLKS + 1);
  localparam int unsigned WW = $clog2(FRAME_TIMEOUT + 1);

  state_t              r_state;
  logic                r_sync1;
  logic                r_ser_s;
  logic [IW-1:0]       r_idle_cnt;
  logic [WW-1:0]       r_wd;
  cfg_t                r_shadow;
  cfg_t                r_active;
  logic                r_pending;
  logic                r_rx_reset;
  logic                r_rst_seen;
  logic                r_overrun;
  logic                r_timeout;
  logic [7:0]          r_err_count;

  logic                w_idle_sat;
  logic                w_strobe;
  logic                w_err;
  logic                w_keep;
  logic                w_pop;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic                w_wd_fire;
  logic [ENTRY_W-1:0]  w_entry;
  cfg_t                w_cfg_in;

  assign w_cfg_in   = '{parity_en: cfg_parity_en, baud_mode: cfg_baud_mode, datalen: cfg_datalen};
  assign w_idle_sat = (r_idle_cnt == IW'(IDLE_CLKS));
  assign w_strobe   = (r_state == ST_FRAME) & rx_data_ready;
  assign w_err      = rx_parity_err | rx_frame_err;
  assign w_keep     = w_strobe & ~((DROP_ERR != 0) & w_err);
  assign w_pop      = m_ready & ~w_empty;
  assign w_push     = w_keep & (~w_full | w_pop);
  assign w_wd_fire  = (r_state == ST_FRAME) & ~rx_data_ready & (r_wd == WW'(FRAME_TIMEOUT - 1));

  always_comb begin
    w_entry              = '0;
    w_entry[7:0]         = rx_data;
    w_entry[ERR_PAR_BIT] = rx_parity_err;
    w_entry[ERR_FRM_BIT] = rx_frame_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_ser_s    <= 1'b1;
      r_idle_cnt <= '0;
    end else begin
      r_sync1 <= serial_in;
      r_ser_s <= r_sync1;
      if (!r_ser_s)        r_idle_cnt <= '0;
      else if (!w_idle_sat) r_idle_cnt <= r_idle_cnt + IW'(1);
    end
  end

  // Apply effects are registered on entry so they are visible during the ST_APPLY cycle;
  // an update landing on that same edge keeps cfg_pending set for the new shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wd       <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_pending  <= 1'b0;
      r_rx_reset <= 1'b0;
      r_rst_seen <= 1'b1;
    end else begin
      r_rst_seen <= 1'b0;
      r_rx_reset <= r_rst_seen;
      if (cfg_update) begin
        r_shadow  <= w_cfg_in;
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_pending && w_idle_sat) begin
            r_state    <= ST_APPLY;
            r_active   <= r_shadow;
            r_rx_reset <= 1'b1;
            if (!cfg_update) r_pending <= 1'b0;
          end else if (!r_ser_s) begin
            r_state <= ST_FRAME;
            r_wd    <= '0;
          end
        end
        ST_FRAME: begin
          r_wd <= r_wd + WW'(1);
          if (rx_data_ready) begin
            r_state <= ST_IDLE;
          end else if (w_wd_fire) begin
            r_state    <= ST_IDLE;
            r_rx_reset <= 1'b1;
          end
        end
        ST_APPLY: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || status_clear) begin
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_keep && w_full && !w_pop) r_overrun <= 1'b1;
      if (w_wd_fire)                  r_timeout <= 1'b1;
      if (w_strobe && w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (m_data)
  );

  assign m_valid      = ~w_empty;
  assign cfg_pending  = r_pending;
  assign rx_parity_en = r_active.parity_en;
  assign rx_baud_mode = r_active.baud_mode;
  assign rx_datalen   = r_active.datalen;
  assign rx_reset     = r_rx_reset;
  assign overrun      = r_overrun;
  assign timeout      = r_timeout;
  assign err_count    = r_err_count;

endmodule
